ecj2a: RTL
==========

Name: ecj2a

Overview:
- Jacobian-to-affine converter for the elliptic-curve datapath; the return path that pairs with the point-doubling unit ecpd.
- Takes a Jacobian point (X1,Y1,Z1) over prime field p, as produced by the point-doubling/addition units, and returns affine x = X1·Z1⁻² mod p and y = Y1·Z1⁻³ mod p.
- Contains a binary extended-Euclid inverter and a bit-serial interleaved modular multiplier, both sequenced by one FSM.

Parameters:
WIDTH, 256, field/operand width in bits

Ports:
i_clk    in   1      clock, all logic on rising edge
i_rst_n  in   1      reset, synchronous, active-low
i_start  in   1      start request; an operation launches on a 0->1 transition while idle
X1       in   WIDTH  Jacobian X, < p
Y1       in   WIDTH  Jacobian Y, < p
Z1       in   WIDTH  Jacobian Z, < p
p        in   WIDTH  odd prime modulus, > 2
x_aff    out  WIDTH  affine x
y_aff    out  WIDTH  affine y
o_inf    out  1      result is the point at infinity (Z1 == 0)
o_busy   out  1      operation in progress
o_done   out  1      one-cycle completion pulse

Behaviour:
- Reset: when i_rst_n = 0 at a clock edge:
  - x_aff, y_aff = 0; o_inf, o_busy, o_done = 0.
  - FSM returns to IDLE and the start-edge register clears.
  - Reset mid-operation aborts the operation; no o_done is issued.
- Start detection:
  - A registered copy of i_start is kept. Launch = i_start & ~start_q & (state == IDLE).
  - A start held high never re-triggers.
  - Edges arriving while busy are ignored.
- On launch: X1, Y1, Z1 and p are latched. The inputs may change afterwards without effect. o_busy rises the next cycle.
- FSM states: IDLE -> CHK -> INV -> SQ -> CU -> MX -> MY -> DONE -> IDLE.
- CHK (1 cycle):
  - If Zl == 0: o_inf = 1, x_aff = y_aff = 0, go to DONE.
  - Otherwise clear o_inf and go to INV.
- INV (binary inversion):
  - Init: u = Zl, v = p, a = 1, b = 0.
  - One action per cycle, in priority order:
    - u == 1 or v == 1: finish; zi = (u == 1) ? a : b.
    - u even: u >>= 1; a = a even ? a/2 : (a+p)/2.
    - v even: same on v, b.
    - u >= v: u -= v; a = a - b mod p.
    - else: v -= u; b = b - a mod p.
  - a + p needs a WIDTH+1-bit intermediate.
  - Bounded by 4·WIDTH cycles. If Zl == 1, finishes in the first INV cycle.
- Multiplier (mulmod r = s·t mod p), shared by SQ/CU/MX/MY:
  - Runs WIDTH iterations, MSB first: r = 2r mod p, then if bit set r = r + s mod p.
  - Each conditional subtract compares in WIDTH+1 bits.
  - 1 load cycle + WIDTH iteration cycles.
- Multiply sequence:
  - SQ: z2 = zi·zi
  - CU: z3 = z2·zi
  - MX: x_aff = Xl·z2
  - MY: y_aff = Yl·z3
- Output timing:
  - x_aff is written at the end of MX; y_aff at the end of MY.
  - Outputs hold until the next launch or reset. Intermediate values never appear on x_aff/y_aff during MX.
- DONE (1 cycle): o_done = 1, o_busy = 0 on the same cycle, then IDLE.
- Latency from launch edge to o_done:
  - Z1 == 0: exactly 3 cycles.
  - Otherwise at most 4·WIDTH + 4·(WIDTH+1) + 4 cycles. Results are bit-exact regardless of latency.
- Inputs ≥ p or a non-prime p: result undefined, but the FSM must still terminate. INV aborts to DONE if v reaches 0.

Test Plan:
- p = FFFFFFFF…FFFEFFFFFC2F (secp256k1), X1 = 79BE667E…16F81798, Y1 = 483ADA77…FB10D4B8, Z1 = 1, single 0->1 start -> x_aff = X1, y_aff = Y1, o_inf = 0, exactly one o_done pulse.
- p = 23, X1 = 12, Y1 = 11, Z1 = 2 -> x_aff = 3, y_aff = 10; check intermediates zi = 12, z2 = 6, z3 = 3.
- p = 23, X1 = 3, Y1 = 13, Z1 = 22 -> x_aff = 3, y_aff = 10. i_start held high for 2000 cycles after o_done -> no second o_done.
- Z1 = 0, any X1/Y1 -> o_done 3 cycles after the launch edge, o_inf = 1, x_aff = y_aff = 0. A following valid operation clears o_inf.
- Pulse i_start again mid-INV with different inputs -> ignored; result matches the original inputs. Drive i_rst_n = 0 for 1 cycle mid-MX -> all outputs 0 on the next cycle, no o_done. A fresh start then completes correctly.
- Randomised regression, 200 points, p = secp256k1 prime: random affine (x,y) and random λ ≠ 0, drive X = x·λ², Y = y·λ³, Z = λ -> outputs equal (x,y), latency within bound.

Source files
------------

// File: rtl/ecj2a.sv
// ecj2a: Jacobian (X1,Y1,Z1) to affine (x,y) converter over GF(p).
// Binary extended-Euclid inverter plus a shared bit-serial interleaved
// modular multiplier, sequenced by a single FSM.
module ecj2a #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] X1,
  input  logic [WIDTH-1:0] Y1,
  input  logic [WIDTH-1:0] Z1,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] x_aff,
  output logic [WIDTH-1:0] y_aff,
  output logic             o_inf,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHK, S_INV, S_SQ, S_CU, S_MX, S_MY, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] xl_q, xl_d, yl_q, yl_d, zl_q, zl_d, pl_q, pl_d;
  logic [WIDTH-1:0] u_q, u_d, v_q, v_d, a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] zi_q, zi_d, z2_q, z2_d, z3_q, z3_d;
  logic [WIDTH-1:0] r_q, r_d, t_q, t_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic             inf_q, inf_d, busy_q, busy_d, done_q, done_d;

  logic             launch;
  logic [WIDTH:0]   a_sum, b_sum, r_dbl, r_add;
  logic [WIDTH-1:0] a_half, b_half, ab_sub, ba_sub;
  logic [WIDTH-1:0] mul_s, mul_t, r_nxt;

  // Inverter step helpers: halving mod p and subtraction mod p.
  always_comb begin
    a_sum  = {1'b0, a_q} + (a_q[0] ? {1'b0, pl_q} : '0);
    b_sum  = {1'b0, b_q} + (b_q[0] ? {1'b0, pl_q} : '0);
    a_half = WIDTH'(a_sum >> 1);
    b_half = WIDTH'(b_sum >> 1);
    ab_sub = (a_q >= b_q) ? (a_q - b_q) : (a_q - b_q + pl_q);
    ba_sub = (b_q >= a_q) ? (b_q - a_q) : (b_q - a_q + pl_q);
  end

  // Multiplier operand select and one interleaved iteration: r = 2r (+s) mod p.
  always_comb begin
    mul_s = zi_q;
    mul_t = zi_q;
    case (state_q)
      S_CU: begin mul_s = zi_q; mul_t = z2_q; end
      S_MX: begin mul_s = z2_q; mul_t = xl_q; end
      S_MY: begin mul_s = z3_q; mul_t = yl_q; end
      default: ;
    endcase
    r_dbl = {r_q, 1'b0};
    if (r_dbl >= {1'b0, pl_q}) r_dbl = r_dbl - {1'b0, pl_q};
    r_add = {1'b0, WIDTH'(r_dbl)} + {1'b0, mul_s};
    if (r_add >= {1'b0, pl_q}) r_add = r_add - {1'b0, pl_q};
    r_nxt = t_q[WIDTH-1] ? WIDTH'(r_add) : WIDTH'(r_dbl);
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    start_d = i_start;
    xl_d = xl_q;  yl_d = yl_q;  zl_d = zl_q;  pl_d = pl_q;
    u_d  = u_q;   v_d  = v_q;   a_d  = a_q;   b_d  = b_q;
    zi_d = zi_q;  z2_d = z2_q;  z3_d = z3_q;
    r_d  = r_q;   t_d  = t_q;   cnt_d = cnt_q; run_d = run_q;
    x_d  = x_q;   y_d  = y_q;
    inf_d = inf_q; busy_d = busy_q; done_d = 1'b0;
    launch = i_start & ~start_q & (state_q == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          xl_d = X1; yl_d = Y1; zl_d = Z1; pl_d = p;
          busy_d  = 1'b1;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (zl_q == '0) begin
          inf_d = 1'b1; x_d = '0; y_d = '0;
          state_d = S_DONE;
        end else begin
          inf_d = 1'b0;
          u_d = zl_q; v_d = pl_q; a_d = ONE; b_d = '0;
          state_d = S_INV;
        end
      end
      S_INV: begin
        // u == 0 can only arise from out-of-range inputs; abort to guarantee termination.
        if (u_q == ONE || v_q == ONE) begin
          zi_d    = (u_q == ONE) ? a_q : b_q;
          state_d = S_SQ;
        end else if (u_q == '0 || v_q == '0) begin
          state_d = S_DONE;
        end else if (!u_q[0]) begin
          u_d = u_q >> 1; a_d = a_half;
        end else if (!v_q[0]) begin
          v_d = v_q >> 1; b_d = b_half;
        end else if (u_q >= v_q) begin
          u_d = u_q - v_q; a_d = ab_sub;
        end else begin
          v_d = v_q - u_q; b_d = ba_sub;
        end
      end
      S_SQ, S_CU, S_MX, S_MY: begin
        if (!run_q) begin
          r_d = '0; t_d = mul_t; cnt_d = '0; run_d = 1'b1;
        end else begin
          r_d   = r_nxt;
          t_d   = t_q << 1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            run_d = 1'b0;
            case (state_q)
              S_SQ:    begin z2_d = r_nxt; state_d = S_CU;   end
              S_CU:    begin z3_d = r_nxt; state_d = S_MX;   end
              S_MX:    begin x_d  = r_nxt; state_d = S_MY;   end
              default: begin y_d  = r_nxt; state_d = S_DONE; end
            endcase
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      xl_q <= '0; yl_q <= '0; zl_q <= '0; pl_q <= '0;
      u_q  <= '0; v_q  <= '0; a_q  <= '0; b_q  <= '0;
      zi_q <= '0; z2_q <= '0; z3_q <= '0;
      r_q  <= '0; t_q  <= '0; cnt_q <= '0; run_q <= 1'b0;
      x_q  <= '0; y_q  <= '0;
      inf_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      xl_q <= xl_d; yl_q <= yl_d; zl_q <= zl_d; pl_q <= pl_d;
      u_q  <= u_d;  v_q  <= v_d;  a_q  <= a_d;  b_q  <= b_d;
      zi_q <= zi_d; z2_q <= z2_d; z3_q <= z3_d;
      r_q  <= r_d;  t_q  <= t_d;  cnt_q <= cnt_d; run_q <= run_d;
      x_q  <= x_d;  y_q  <= y_d;
      inf_q <= inf_d; busy_q <= busy_d; done_q <= done_d;
    end
  end

  assign x_aff  = x_q;
  assign y_aff  = y_q;
  assign o_inf  = inf_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule
